// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its decode helpers.
package keypad_pkg;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int KEY_CODE_W = 4;
  localparam int CAND_W     = KEY_CODE_W + 1;

  typedef logic [CAND_W-1:0] cand_t;

  // MSB set means "no key seen"; real codes are {1'b0, row, col}
  localparam cand_t CAND_NONE = 5'b1_0000;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } key_state_e;

  function automatic cand_t first_col(input logic [1:0] row, input logic [COLS-1:0] col_n);
    cand_t c;
    c = CAND_NONE;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!col_n[i]) c = {1'b0, row, 2'(i)};
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; 2-cycle latency.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with frame-level debounce and one valid pulse per accepted press.
// Optional auto-repeat of key_valid while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES         = 100_000,
  parameter int DEBOUNCE_SCANS      = 4,
  parameter int REPEAT_DELAY_FRAMES = 500,
  parameter int REPEAT_RATE_FRAMES  = 100
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [COLS-1:0]       col_in,
  output logic [ROWS-1:0]       row_out,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);

  localparam int                DWELL_W    = $clog2(SCAN_CYCLES);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
  localparam int                CNT_W      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0]  STABLE_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic [COLS-1:0] col_sync;

  sync_2ff #(
    .WIDTH     (COLS),
    .RESET_VAL ({COLS{1'b1}})
  ) u_col_sync (
    .clk   (clk),
    .nrst  (nrst),
    .d_in  (col_in),
    .q_out (col_sync)
  );

  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [1:0]            row_idx_q, row_idx_d;
  logic [ROWS-1:0]       row_out_q, row_out_d;
  cand_t                 cand_q, cand_d;
  cand_t                 prev_cand_q, prev_cand_d;
  logic [CNT_W-1:0]      stable_q, stable_d;
  key_state_e            state_q, state_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  key_held_q, key_held_d;

  logic  sample;
  logic  frame_end;
  logic  settled;
  cand_t cand_now;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                           REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;
  logic [RPT_W-1:0] rpt_next;
  logic [RPT_W-1:0] rpt_limit;
`endif

  always_comb begin
    dwell_d     = dwell_q;
    row_idx_d   = row_idx_q;
    row_out_d   = row_out_q;
    cand_d      = cand_q;
    prev_cand_d = prev_cand_q;
    stable_d    = stable_q;
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_next    = rpt_cnt_q + RPT_W'(1);
    rpt_limit   = rpt_first_q ? RPT_W'(REPEAT_DELAY_FRAMES) : RPT_W'(REPEAT_RATE_FRAMES);
`endif

    sample    = (dwell_q == DWELL_LAST);
    frame_end = sample && (row_idx_q == 2'd3);
    // An earlier row's hit in this frame outranks anything found later
    cand_now  = (cand_q != CAND_NONE) ? cand_q : first_col(row_idx_q, col_sync);

    if (sample) begin
      dwell_d   = '0;
      row_idx_d = row_idx_q + 2'd1;
      row_out_d = {row_out_q[ROWS-2:0], row_out_q[ROWS-1]};
      cand_d    = frame_end ? CAND_NONE : cand_now;
    end else begin
      dwell_d = dwell_q + DWELL_W'(1);
    end

    if (frame_end) begin
      if (cand_now == prev_cand_q) begin
        stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + CNT_W'(1);
      end else begin
        stable_d = CNT_W'(1);
      end
      prev_cand_d = cand_now;
    end

    settled = frame_end && (stable_d == STABLE_MAX);

    case (state_q)
      RELEASED: begin
        if (settled && (cand_now != CAND_NONE)) begin
          state_d     = PRESSED;
          key_code_d  = cand_now[KEY_CODE_W-1:0];
          key_held_d  = 1'b1;
          key_valid_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b1;
`endif
        end
      end
      PRESSED: begin
        // A different stable key is ignored; only a settled release leaves
        if (settled && (cand_now == CAND_NONE)) begin
          state_d    = RELEASED;
          key_held_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b1;
        end else if (frame_end) begin
          if (rpt_next == rpt_limit) begin
            key_valid_d = 1'b1;
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
          end else begin
            rpt_cnt_d = rpt_next;
          end
`endif
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dwell_q     <= '0;
      row_idx_q   <= 2'd0;
      row_out_q   <= 4'b1110;
      cand_q      <= CAND_NONE;
      prev_cand_q <= CAND_NONE;
      stable_q    <= '0;
      state_q     <= RELEASED;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      dwell_q     <= dwell_d;
      row_idx_q   <= row_idx_d;
      row_out_q   <= row_out_d;
      cand_q      <= cand_d;
      prev_cand_q <= prev_cand_d;
      stable_q    <= stable_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`endif

  assign row_out   = row_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix model.
module tb_keypad_scanner;

  localparam int SCAN  = 8;
  localparam int FRAME = 4 * SCAN;

  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_total = 0;
  int consec_errs = 0;
  logic valid_prev = 1'b0;

  keypad_scanner #(
    .SCAN_CYCLES         (SCAN),
    .DEBOUNCE_SCANS      (3),
    .REPEAT_DELAY_FRAMES (4),
    .REPEAT_RATE_FRAMES  (2)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Pressed key pulls its column low only while its row is driven low
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (key_valid) pulse_total++;
    if (key_valid && valid_prev) consec_errs++;
    valid_prev = key_valid;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Land on the negedge just after a frame-end edge (row_out back to row 0)
  task automatic align();
    logic [3:0] prev;
    int guard;
    for (guard = 0; guard < 200; guard++) begin
      prev = row_out;
      @(negedge clk);
      if (prev == 4'b0111 && row_out == 4'b1110) break;
    end
    if (guard >= 200) check("align_timeout", 0, 1);
  endtask

  typedef struct {
    logic [15:0] keys;
    int          pulses;
    int          pulses_rpt;
    logic [3:0]  code;
    logic        held;
  } vec_t;

  vec_t vecs[8];
  logic [3:0] rot_exp[5];
  int base;
  int exp_p;

  initial begin
    vecs[0] = '{16'h0000, 0, 0, 4'h0, 1'b0};
    vecs[1] = '{16'h0200, 1, 1, 4'h9, 1'b1};
    vecs[2] = '{16'h0000, 0, 0, 4'h9, 1'b0};
    vecs[3] = '{16'h0180, 1, 1, 4'h7, 1'b1};
    vecs[4] = '{16'h0100, 0, 1, 4'h7, 1'b1};
    vecs[5] = '{16'h0000, 0, 1, 4'h7, 1'b0};
    vecs[6] = '{16'h4000, 1, 1, 4'hE, 1'b1};
    vecs[7] = '{16'h0000, 0, 0, 4'hE, 1'b0};
    rot_exp[0] = 4'b1110;
    rot_exp[1] = 4'b1101;
    rot_exp[2] = 4'b1011;
    rot_exp[3] = 4'b0111;
    rot_exp[4] = 4'b1110;

    keys = '0;
    nrst = 1'b0;
    wait_cyc(3);
    check("rst_row_out", int'(row_out), 14);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_held", int'(key_held), 0);
    nrst = 1'b1;
    wait_cyc(4);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rotate_%0d", i), int'(row_out), int'(rot_exp[i]));
      wait_cyc(SCAN);
    end

    base = pulse_total;
    align();
    for (int i = 0; i < 8; i++) begin
      keys = vecs[i].keys;
      wait_cyc(3 * FRAME + 4);
`ifdef KEYPAD_REPEAT_EN
      exp_p = vecs[i].pulses_rpt;
`else
      exp_p = vecs[i].pulses;
`endif
      check($sformatf("vec%0d_pulses", i), pulse_total - base, exp_p);
      check($sformatf("vec%0d_code", i), int'(key_code), int'(vecs[i].code));
      check($sformatf("vec%0d_held", i), int'(key_held), int'(vecs[i].held));
      base = pulse_total;
      align();
    end

    // Bounce on row 0 / col 0 for two whole frames, then a steady press
    base = pulse_total;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i % 5 == 0) keys[0] = ~keys[0];
      @(negedge clk);
    end
    keys[0] = 1'b1;
    check("bounce_quiet", pulse_total - base, 0);
    wait_cyc(4 * FRAME + 8);
    check("bounce_pulses", pulse_total - base, 1);
    check("bounce_code", int'(key_code), 0);
    check("bounce_held", int'(key_held), 1);
    keys = '0;
    wait_cyc(5 * FRAME);
    check("bounce_release_held", int'(key_held), 0);

    // Reset while a key is held and accepted
    align();
    keys = 16'h0400;
    wait_cyc(4 * FRAME);
    check("midhold_pre_held", int'(key_held), 1);
    nrst = 1'b0;
    #1;
    check("midhold_rst_code", int'(key_code), 0);
    check("midhold_rst_held", int'(key_held), 0);
    check("midhold_rst_valid", int'(key_valid), 0);
    check("midhold_rst_row", int'(row_out), 14);
    wait_cyc(2);
    nrst = 1'b1;
    base = pulse_total;
    wait_cyc(3 * FRAME - 6);
    check("midhold_early_pulses", pulse_total - base, 0);
    wait_cyc(10);
    check("midhold_pulses", pulse_total - base, 1);
    check("midhold_code", int'(key_code), 10);
    check("midhold_held", int'(key_held), 1);
    keys = '0;
    wait_cyc(5 * FRAME);
    check("midhold_release_held", int'(key_held), 0);

    // Long hold of key 5: auto-repeat only when the feature is built in
    align();
    base = pulse_total;
    keys = 16'h0020;
    wait_cyc(3 * FRAME + 4);
    check("hold5_accept_pulses", pulse_total - base, 1);
    check("hold5_code", int'(key_code), 5);
    wait_cyc(4 * FRAME);
`ifdef KEYPAD_REPEAT_EN
    check("hold5_after_delay", pulse_total - base, 2);
`else
    check("hold5_after_delay", pulse_total - base, 1);
`endif
    wait_cyc(2 * FRAME);
`ifdef KEYPAD_REPEAT_EN
    check("hold5_after_rate", pulse_total - base, 3);
`else
    check("hold5_after_rate", pulse_total - base, 1);
`endif
    check("hold5_code_kept", int'(key_code), 5);
    keys = '0;
    wait_cyc(5 * FRAME);
    check("hold5_release_held", int'(key_held), 0);
    check("hold5_code_after_release", int'(key_code), 5);

    check("valid_single_cycle", consec_errs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
